// File: rtl/rotation_sequencer_if.sv
// Handshake/bus bundle for rotation_sequencer: move tick, buttons, snap command and step outputs.
interface rotation_sequencer_if #(
    parameter int unsigned IDX_W = 5
);
    logic             tick;
    logic             left;
    logic             right;
    logic             snap_req;
    logic [IDX_W-1:0] snap_idx;
    logic             snap_busy;
    logic             step_right;
    logic             step_left;
    logic [IDX_W-1:0] heading_idx;

    modport master (
        output tick, left, right, snap_req, snap_idx,
        input  snap_busy, step_right, step_left, heading_idx
    );

    modport slave (
        input  tick, left, right, snap_req, snap_idx,
        output snap_busy, step_right, step_left, heading_idx
    );
endinterface

// File: rtl/rotation_sequencer.sv
// Heading sequencer: button hold-to-repeat stepping and shortest-path snap for the 2^IDX_W-step rotation datapath.
// Optional macro ROT_ACCEL_EN: halves the repeat interval after 8 consecutive repeat steps.
module rotation_sequencer #(
    parameter int unsigned HOLD_DELAY    = 12,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int unsigned IDX_W         = 5
) (
    input logic                  clock,
    input logic                  resetn,
    rotation_sequencer_if.slave  bus
);
    localparam int unsigned MAX_CNT = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [IDX_W-1:0] HALF_TURN = IDX_W'(1) << (IDX_W - 1);
`ifdef ROT_ACCEL_EN
    localparam int unsigned FAST_PERIOD = (REPEAT_PERIOD / 2 > 1) ? REPEAT_PERIOD / 2 : 1;
    localparam int unsigned REP_W       = 4;
    localparam logic [REP_W-1:0] ACCEL_AFTER = REP_W'(8);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT, ST_SNAP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_r_q, dir_r_d;
    logic [IDX_W-1:0] heading_q, heading_d;
    logic [IDX_W-1:0] target_q, target_d;
    logic             busy_q, busy_d;
    logic             step_r_q, step_r_d;
    logic             step_l_q, step_l_d;
`ifdef ROT_ACCEL_EN
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_next;
`endif

    logic             rot_r, rot_l, held;
    logic             emit_r, emit_l;
    logic [CNT_W-1:0] repeat_reload;
    logic [IDX_W-1:0] diff;

    assign rot_r = bus.right & ~bus.left;
    assign rot_l = bus.left & ~bus.right;
    assign held  = dir_r_q ? rot_r : rot_l;
    assign diff  = target_q - heading_q;

`ifdef ROT_ACCEL_EN
    assign rep_next      = (rep_q >= ACCEL_AFTER) ? rep_q : rep_q + REP_W'(1);
    assign repeat_reload = (rep_next >= ACCEL_AFTER) ? CNT_W'(FAST_PERIOD - 1)
                                                     : CNT_W'(REPEAT_PERIOD - 1);
`else
    assign repeat_reload = CNT_W'(REPEAT_PERIOD - 1);
`endif

    // Next-state: snap acceptance outranks every button-driven transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_r_d   = dir_r_q;
        target_d  = target_q;
        busy_d    = busy_q;
        emit_r    = 1'b0;
        emit_l    = 1'b0;
`ifdef ROT_ACCEL_EN
        rep_d     = rep_q;
`endif
        if (bus.snap_req && !busy_q) begin
            target_d = bus.snap_idx;
            busy_d   = 1'b1;
            state_d  = ST_SNAP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.tick && (rot_r || rot_l)) begin
                        emit_r  = rot_r;
                        emit_l  = rot_l;
                        dir_r_d = rot_r;
                        cnt_d   = CNT_W'(HOLD_DELAY - 1);
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!held) begin
                        state_d = ST_IDLE;
                    end else if (bus.tick) begin
                        if (cnt_q == '0) begin
                            emit_r  = dir_r_q;
                            emit_l  = ~dir_r_q;
                            cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
                            state_d = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_d = ST_IDLE;
                    end else if (bus.tick) begin
                        if (cnt_q == '0) begin
                            emit_r = dir_r_q;
                            emit_l = ~dir_r_q;
                            cnt_d  = repeat_reload;
`ifdef ROT_ACCEL_EN
                            rep_d  = rep_next;
`endif
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_SNAP: begin
                    if (diff == '0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (bus.tick) begin
                        // Exactly half a turn resolves clockwise
                        emit_r = (diff <= HALF_TURN);
                        emit_l = (diff > HALF_TURN);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef ROT_ACCEL_EN
        if (state_d != ST_REPEAT) rep_d = '0;
`endif
        step_r_d  = emit_r;
        step_l_d  = emit_l;
        heading_d = emit_r ? heading_q + IDX_W'(1) :
                    emit_l ? heading_q - IDX_W'(1) : heading_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_r_q   <= 1'b0;
            heading_q <= '0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            step_r_q  <= 1'b0;
            step_l_q  <= 1'b0;
`ifdef ROT_ACCEL_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_r_q   <= dir_r_d;
            heading_q <= heading_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            step_r_q  <= step_r_d;
            step_l_q  <= step_l_d;
`ifdef ROT_ACCEL_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign bus.snap_busy   = busy_q;
    assign bus.step_right  = step_r_q;
    assign bus.step_left   = step_l_q;
    assign bus.heading_idx = heading_q;
endmodule
